sram_arb_bridge: RTL and testbench

Parametrised N-channel arbiter bridging several SRAM-style requesters (instruction fetch, data access, future cache refill) onto one shared synchronous SRAM port with fixed one-cycle read latency. It adds per-channel valid/ready handshakes, round-robin arbitration and per-channel response buffering, so a stalled requester never loses returned data. It sits between the pipeline stages and the single memory port at the top level of the CPU.

---
 rtl/sram_arb_bridge_pkg.sv | 20 ++
 rtl/sram_resp_fifo.sv | 57 +++++
 rtl/sram_arb_bridge.sv | 116 +++++++++++
 tb/tb_sram_arb_bridge.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_bridge_pkg.sv
// Shared types and helpers for the SRAM arbitration bridge.
// Holds the top-level channel count and the in-flight tag layout.
package sram_arb_bridge_pkg;

    localparam int ARB_NUM_CH = 2;
    // Wide enough for the largest supported channel count (8).
    localparam int CH_IDX_W   = 3;

    typedef struct packed {
        logic                valid;
        logic [CH_IDX_W-1:0] ch;
        logic                is_write;
    } tag_t;

    function automatic logic [CH_IDX_W-1:0] rr_next(input logic [CH_IDX_W-1:0] idx,
                                                    input int num_ch);
        return (int'(idx) == num_ch - 1) ? '0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Per-channel response FIFO: holds returned read data / write acks until
// the requester consumes them. Output reads as zero while empty.
module sram_resp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_arb_bridge.sv
// N-channel round-robin arbiter onto one synchronous SRAM port with
// credit-based per-channel response buffering.
module sram_arb_bridge
    import sram_arb_bridge_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_wr,
    input  logic [NUM_CH*DATA_W/8-1:0]   req_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
    input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
    output logic [NUM_CH-1:0]            resp_valid,
    input  logic [NUM_CH-1:0]            resp_ready,
    output logic [NUM_CH*DATA_W-1:0]     resp_rdata,
    output logic                         mem_en,
    output logic [DATA_W/8-1:0]          mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;

    tag_t                tag_q;
    logic [CH_IDX_W-1:0] rr_ptr_q;
    logic                gnt_valid;
    logic [CH_IDX_W-1:0] gnt_idx;
    logic                gnt_wr;
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   fifo_full;
    logic [NUM_CH-1:0]   fifo_empty;
    logic [CNT_W-1:0]    fifo_count [NUM_CH];
    logic [DATA_W-1:0]   push_data;

    assign push_data = tag_q.is_write ? '0 : mem_rdata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic inflight;
        assign inflight = tag_q.valid && (tag_q.ch == CH_IDX_W'(i));
        // Credit: queued responses plus the one in flight must leave a free slot.
        assign eligible[i] = req_valid[i] && !fifo_full[i] &&
                             !(inflight && fifo_count[i] == CNT_W'(RESP_DEPTH - 1));
        assign resp_valid[i] = !fifo_empty[i];

        sram_resp_fifo #(.DATA_W(DATA_W), .DEPTH(RESP_DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (inflight),
            .push_data(push_data),
            .pop      (resp_valid[i] && resp_ready[i]),
            .pop_data (resp_rdata[i*DATA_W +: DATA_W]),
            .count    (fifo_count[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i])
        );
    end

    // Two passes: channels at or above rr_ptr first, then the wrapped-around ones.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_valid && eligible[i] && CH_IDX_W'(i) >= rr_ptr_q) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = CH_IDX_W'(i);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_valid && eligible[i] && CH_IDX_W'(i) < rr_ptr_q) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = CH_IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mem_en    = gnt_valid;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        gnt_wr    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_valid && gnt_idx == CH_IDX_W'(i)) begin
                req_ready[i] = 1'b1;
                gnt_wr       = req_wr[i];
                mem_we       = req_wr[i] ? req_wstrb[i*STRB_W +: STRB_W] : '0;
                mem_addr     = req_addr[i*ADDR_W +: ADDR_W];
                mem_wdata    = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            tag_q <= '{valid: gnt_valid, ch: gnt_idx, is_write: gnt_wr};
            if (gnt_valid) begin
                rr_ptr_q <= rr_next(gnt_idx, NUM_CH);
            end
        end
    end

endmodule

// File: tb/tb_sram_arb_bridge.sv
// Self-checking bench for sram_arb_bridge (4 channels, 4-deep response FIFOs)
// with a transaction-level reference model and a simple SRAM behind the port.
module tb_sram_arb_bridge;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int D  = 4;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid, req_ready, req_wr, resp_valid, resp_ready;
    logic [N*SW-1:0] req_wstrb;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, resp_rdata;
    logic            mem_en;
    logic [SW-1:0]   mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    sram_arb_bridge #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM environment: one-cycle read latency, byte write enables.
    logic [DW-1:0] sram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= sram[mem_addr[9:2]];
            for (int b = 0; b < SW; b++)
                if (mem_we[b]) sram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE0000 + i * 32'h00010203;
    endfunction

    // Stimulus
    logic [N-1:0]  v_valid, v_wr, v_rready;
    logic [SW-1:0] v_strb  [N];
    logic [AW-1:0] v_addr  [N];
    logic [DW-1:0] v_wdata [N];

    // Reference model
    typedef struct { logic [DW-1:0] data; int avail; } exp_t;
    logic [DW-1:0] ref_mem [256];
    exp_t          exp_q [N][$];
    int            outst [N];
    int            rr;
    int            cyc;

    // Observations from the last step
    logic [N-1:0]  obs_ready, obs_resp_valid;
    logic          obs_mem_en;
    logic [SW-1:0] obs_mem_we;
    logic [AW-1:0] obs_mem_addr;
    logic [DW-1:0] obs_rdata [N];

    int errors = 0;
    int checks = 0;

    task automatic drive_inputs();
        for (int c = 0; c < N; c++) begin
            req_wstrb[c*SW +: SW] = v_strb[c];
            req_addr[c*AW +: AW]  = v_addr[c];
            req_wdata[c*DW +: DW] = v_wdata[c];
        end
        req_valid  = v_valid;
        req_wr     = v_wr;
        resp_ready = v_rready;
    endtask

    task automatic clear_stim();
        v_valid = '0; v_wr = '0; v_rready = '0;
        for (int c = 0; c < N; c++) begin
            v_strb[c] = '0; v_addr[c] = '0; v_wdata[c] = '0;
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            exp_q[c].delete();
            outst[c] = 0;
        end
        rr = 0;
    endtask

    // Applies stimulus for one cycle, compares against the model at the
    // falling edge, commits the cycle's handshakes, returns just after the rise.
    task automatic step();
        int            g, best, d, idx;
        logic [N-1:0]  exp_ready, exp_valid;
        logic [SW-1:0] exp_we;
        exp_t          e;
        drive_inputs();
        @(negedge clk);
        obs_ready = req_ready; obs_resp_valid = resp_valid; obs_mem_en = mem_en;
        obs_mem_we = mem_we; obs_mem_addr = mem_addr;
        for (int c = 0; c < N; c++) obs_rdata[c] = resp_rdata[c*DW +: DW];

        // Grant = eligible channel closest to rr going upward (mod N).
        g = -1; best = N;
        for (int i = 0; i < N; i++) begin
            if (v_valid[i] && outst[i] < D) begin
                d = (i - rr + N) % N;
                if (d < best) begin best = d; g = i; end
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        checks++;
        if (req_ready !== exp_ready) begin
            errors++; $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready);
        end
        checks++;
        if (mem_en !== (g >= 0)) begin
            errors++; $display("FAIL mem_en cyc=%0d: got %b expected %b", cyc, mem_en, g >= 0);
        end
        exp_we = (g >= 0 && v_wr[g]) ? v_strb[g] : '0;
        checks++;
        if (mem_we !== exp_we) begin
            errors++; $display("FAIL mem_we cyc=%0d: got %h expected %h", cyc, mem_we, exp_we);
        end
        if (g >= 0) begin
            checks++;
            if (mem_addr !== v_addr[g]) begin
                errors++; $display("FAIL mem_addr cyc=%0d: got %h expected %h", cyc, mem_addr, v_addr[g]);
            end
            if (v_wr[g]) begin
                checks++;
                if (mem_wdata !== v_wdata[g]) begin
                    errors++; $display("FAIL mem_wdata cyc=%0d: got %h expected %h", cyc, mem_wdata, v_wdata[g]);
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            exp_valid[c] = (exp_q[c].size() > 0) && (exp_q[c][0].avail <= cyc);
            checks++;
            if (resp_valid[c] !== exp_valid[c]) begin
                errors++; $display("FAIL resp_valid[%0d] cyc=%0d: got %b expected %b", c, cyc, resp_valid[c], exp_valid[c]);
            end
            if (exp_valid[c]) begin
                checks++;
                if (obs_rdata[c] !== exp_q[c][0].data) begin
                    errors++; $display("FAIL resp_rdata[%0d] cyc=%0d: got %h expected %h", c, cyc, obs_rdata[c], exp_q[c][0].data);
                end
            end
        end

        for (int c = 0; c < N; c++) begin
            if (exp_valid[c] && v_rready[c]) begin
                void'(exp_q[c].pop_front());
                outst[c]--;
            end
        end
        if (g >= 0) begin
            idx = int'(v_addr[g][9:2]);
            e.data  = v_wr[g] ? '0 : ref_mem[idx];
            e.avail = cyc + 2;
            exp_q[g].push_back(e);
            outst[g]++;
            if (v_wr[g])
                for (int b = 0; b < SW; b++)
                    if (v_strb[g][b]) ref_mem[idx][b*8 +: 8] = v_wdata[g][b*8 +: 8];
            rr = (g + 1) % N;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_stim();
        drive_inputs();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_stim();
        v_valid = '1; v_wr = '1; v_rready = '1;
        for (int c = 0; c < N; c++) v_strb[c] = '1;
        drive_inputs();
        #1;
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        checks++;
        if (mem_we !== '0) begin errors++; $display("FAIL reset_mem_we: got %h expected 0", mem_we); end
        checks++;
        if (resp_valid !== '0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++;
        if (resp_rdata !== '0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        // First cycle out of reset: all channels request, rr_ptr=0 picks ch0.
        step();
        checks++;
        if (obs_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", obs_ready); end
        v_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_single_read();
        apply_reset();
        v_rready = '1;
        v_valid[0] = 1'b1; v_addr[0] = 32'h100;
        step();
        checks++;
        if (obs_mem_en !== 1'b1 || obs_mem_addr !== 32'h100) begin
            errors++; $display("FAIL single_read_issue: got en=%b addr=%h expected en=1 addr=100", obs_mem_en, obs_mem_addr);
        end
        v_valid = '0;
        step();
        checks++;
        if (obs_resp_valid[0] !== 1'b0) begin errors++; $display("FAIL single_read_early: got %b expected 0", obs_resp_valid[0]); end
        step();
        checks++;
        if (obs_resp_valid[0] !== 1'b1 || obs_rdata[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_read_resp: got v=%b d=%h expected v=1 d=deadbeef", obs_resp_valid[0], obs_rdata[0]);
        end
        step();
        checks++;
        if (obs_resp_valid[0] !== 1'b0) begin errors++; $display("FAIL single_read_after: got %b expected 0", obs_resp_valid[0]); end
    endtask

    task automatic test_write_ack();
        logic [DW-1:0] merged;
        apply_reset();
        v_rready = '1;
        v_valid[1] = 1'b1; v_wr[1] = 1'b1; v_strb[1] = 4'h3;
        v_addr[1] = 32'h40; v_wdata[1] = 32'h12345678;
        step();
        checks++;
        if (obs_mem_we !== 4'h3 || obs_ready !== 4'b0010) begin
            errors++; $display("FAIL write_issue: got we=%h ready=%b expected we=3 ready=0010", obs_mem_we, obs_ready);
        end
        v_valid = '0;
        step();
        step();
        checks++;
        if (obs_resp_valid[1] !== 1'b1 || obs_rdata[1] !== '0) begin
            errors++; $display("FAIL write_ack: got v=%b d=%h expected v=1 d=0", obs_resp_valid[1], obs_rdata[1]);
        end
        v_valid[0] = 1'b1; v_addr[0] = 32'h40;
        step();
        v_valid = '0;
        step();
        step();
        merged = {init_word(16)[31:16], 16'h5678};
        checks++;
        if (obs_rdata[0] !== merged) begin
            errors++; $display("FAIL write_readback: got %h expected %h", obs_rdata[0], merged);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] want;
        apply_reset();
        v_rready = '1;
        for (int k = 0; k < 12; k++) begin
            v_valid = 4'b0011;
            v_addr[0] = $urandom; v_addr[1] = $urandom;
            step();
            want = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++;
            if (obs_ready !== want) begin
                errors++; $display("FAIL contention_grant k=%0d: got %b expected %b", k, obs_ready, want);
            end
        end
        v_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_backpressure();
        int acc;
        apply_reset();
        v_rready = 4'b1101;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            v_valid = 4'b0010; v_addr[1] = $urandom;
            step();
            acc += int'(obs_ready[1]);
        end
        checks++;
        if (acc != D) begin errors++; $display("FAIL backpressure_accepts: got %0d expected %0d", acc, D); end
        checks++;
        if (obs_ready[1] !== 1'b0 || obs_resp_valid[1] !== 1'b1) begin
            errors++; $display("FAIL backpressure_stall: got ready=%b valid=%b expected ready=0 valid=1", obs_ready[1], obs_resp_valid[1]);
        end
        v_rready = '1;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            v_addr[1] = $urandom;
            step();
            acc += int'(obs_ready[1]);
        end
        checks++;
        if (acc != 9) begin errors++; $display("FAIL backpressure_resume: got %0d expected 9", acc); end
        v_valid = '0;
        repeat (8) step();
    endtask

    task automatic test_back_to_back();
        int acc;
        apply_reset();
        v_rready = '1;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            v_valid = 4'b0100; v_wr[2] = 1'(($urandom) & 1); v_strb[2] = 4'($urandom);
            v_addr[2] = $urandom; v_wdata[2] = $urandom;
            step();
            acc += int'(obs_ready[2]);
        end
        checks++;
        if (acc != 10) begin errors++; $display("FAIL back_to_back: got %0d expected 10", acc); end
        v_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_reset_midflight();
        int seen;
        apply_reset();
        v_rready = '1;
        v_valid[0] = 1'b1; v_addr[0] = 32'h100;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0 || mem_en !== 1'b0 || mem_we !== '0) begin
            errors++; $display("FAIL midflight_outputs: got ready=%b en=%b we=%h expected 0", req_ready, mem_en, mem_we);
        end
        checks++;
        if (resp_valid !== '0 || resp_rdata !== '0) begin
            errors++; $display("FAIL midflight_resp: got valid=%b rdata=%h expected 0", resp_valid, resp_rdata);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        v_valid = '0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (obs_resp_valid != '0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midflight_no_resp: got %0d cycles with responses expected 0", seen); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N; c++) begin
                v_valid[c]  = ($urandom_range(0, 9) < 6);
                v_wr[c]     = ($urandom_range(0, 3) == 0);
                v_strb[c]   = 4'($urandom);
                v_addr[c]   = $urandom;
                v_wdata[c]  = $urandom;
                v_rready[c] = ($urandom_range(0, 9) < 7);
            end
            step();
        end
        v_valid = '0; v_rready = '1;
        repeat (12) step();
        checks++;
        if (obs_resp_valid !== '0) begin errors++; $display("FAIL random_drain: got %b expected 0", obs_resp_valid); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = init_word(i);
            ref_mem[i] = init_word(i);
        end
        sram[64]    = 32'hDEADBEEF;
        ref_mem[64] = 32'hDEADBEEF;
        cyc = 0;
        model_clear();
        clear_stim();
        drive_inputs();

        test_reset();
        test_single_read();
        test_write_ack();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
